wrr_arbiter: RTL and testbench

//  Parametrised weighted round-robin arbiter with a grant/ack handshake; next generation of the fixed 32-way RR arbiter.
//  N_REQ requesters with per-requester weights set at runtime; weight = back-to-back grants a requester may hold.

---
 rtl/wrr_arbiter_pkg.sv | 18 +
 rtl/wrr_arbiter_if.sv | 49 ++++
 rtl/wrr_arbiter_rr_pick.sv | 45 ++++
 rtl/wrr_arbiter.sv | 153 +++++++++++++++
 tb/tb_wrr_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wrr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wrr_pkg
//   Shared types and defaults for the weighted round-robin arbiter.
//   - wrr_state_e  : arbiter FSM state (IDLE, GRANT), also exported for debug
//   - DEF_N_REQ    : default number of requesters
//   - DEF_WEIGHT_W : default width of a weight / credit counter
// -----------------------------------------------------------------------------
package wrr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } wrr_state_e;

    localparam int DEF_N_REQ    = 32;
    localparam int DEF_WEIGHT_W = 4;

endpackage : wrr_pkg

// File: rtl/wrr_arbiter_if.sv
// -----------------------------------------------------------------------------
// wrr_arbiter_if
//   Request/grant bus between the request sources and the arbiter.
//   Signals:
//     req     : request vector, bit i = requester i
//     ack     : resource is done with the current grant
//     gnt_w   : one-hot grant, all-zero when idle
//     gnt_id  : binary index of the granted requester
//     gnt_vld : a grant is active
//   Modports:
//     master : request side (drives req/ack, observes the grant)
//     slave  : arbiter side (observes req/ack, drives the grant)
//
//   Handshake: a grant (gnt_vld=1, gnt_w/gnt_id) stays stable from the cycle it
//   appears until the cycle in which ack=1 is sampled or req[gnt_id] drops.
//   ack=1 while gnt_vld=1 completes exactly one transaction at that posedge;
//   ack while gnt_vld=0 has no effect. Dropping req[gnt_id] without ack
//   withdraws the request and no transaction is completed.
// -----------------------------------------------------------------------------
interface wrr_arbiter_if
    import wrr_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = $clog2(N_REQ)
) ();

    logic [N_REQ-1:0] req;
    logic             ack;
    logic [N_REQ-1:0] gnt_w;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_vld;

    modport master (
        output req,
        output ack,
        input  gnt_w,
        input  gnt_id,
        input  gnt_vld
    );

    modport slave (
        input  req,
        input  ack,
        output gnt_w,
        output gnt_id,
        output gnt_vld
    );

endinterface : wrr_arbiter_if

// File: rtl/wrr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational rotating-priority encoder: finds the first set bit of vec
//   at or after index start, wrapping from N_REQ-1 back to 0.
//   Ports:
//     vec    in  N_REQ  candidate vector
//     start  in  ID_W   highest-priority index (must be < N_REQ)
//     onehot out N_REQ  one-hot winner, zero when nothing set
//     id     out ID_W   binary winner index, zero when nothing set
//     any    out 1      at least one bit of vec is set
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 32,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] vec,
    input  logic [ID_W-1:0]  start,
    output logic [N_REQ-1:0] onehot,
    output logic [ID_W-1:0]  id,
    output logic             any
);

    int idx;

    always_comb begin
        any    = 1'b0;
        id     = '0;
        onehot = '0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(start) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!any && vec[idx]) begin
                any = 1'b1;
                id  = ID_W'(idx);
            end
        end
        if (any) begin
            onehot[id] = 1'b1;
        end
    end

endmodule : rr_pick

// File: rtl/wrr_arbiter.sv
// -----------------------------------------------------------------------------
// wrr_arbiter
//   Weighted round-robin arbiter with grant/ack handshake. In WRR mode a
//   requester may hold up to weight[i] back-to-back grants; weight 0 masks it.
//   In plain RR mode every requester gets one grant per turn.
//   Ports:
//     clk        in  1               clock, posedge
//     rst        in  1               synchronous reset, active-low
//     mode       in  1               0 = plain RR, 1 = WRR
//     cfg_load   in  1               latch weight_cfg into the weight registers
//     weight_cfg in  N_REQ*WEIGHT_W  weight i at [i*WEIGHT_W +: WEIGHT_W]
//     bus        slave modport       req/ack in, gnt_w/gnt_id/gnt_vld out
//     state_dbg  out wrr_state_e     current FSM state
// -----------------------------------------------------------------------------
module wrr_arbiter
    import wrr_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int WEIGHT_W = DEF_WEIGHT_W,
    parameter int ID_W     = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic                      cfg_load,
    input  logic [N_REQ*WEIGHT_W-1:0] weight_cfg,
    wrr_arbiter_if.slave              bus,
    output wrr_state_e                state_dbg
);

    wrr_state_e          state_q;
    logic [ID_W-1:0]     ptr_q;
    logic [WEIGHT_W-1:0] credit_q;
    logic [WEIGHT_W-1:0] weight_q [N_REQ];
    logic [N_REQ-1:0]    gnt_w_q;
    logic [ID_W-1:0]     gnt_id_q;
    logic                gnt_vld_q;

    logic [N_REQ-1:0]    elig;
    logic [ID_W-1:0]     pick_start;
    logic [N_REQ-1:0]    pick_onehot;
    logic [ID_W-1:0]     pick_id;
    logic                pick_any;
    logic [WEIGHT_W-1:0] pick_w;
    logic [WEIGHT_W-1:0] load_credit;
    logic                regrant;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] cur);
        return (int'(cur) == N_REQ - 1) ? '0 : ID_W'(int'(cur) + 1);
    endfunction

    // Eligibility uses the weights currently held in the registers.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = bus.req[i] && (!mode || (weight_q[i] != '0));
        end
    end

    // After a completed grant the search starts just past the served id, so
    // the served requester is considered last. From IDLE it starts at ptr.
    always_comb begin
        pick_start = (state_q == GRANT) ? next_id(gnt_id_q) : ptr_q;
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .vec    (elig),
        .start  (pick_start),
        .onehot (pick_onehot),
        .id     (pick_id),
        .any    (pick_any)
    );

    // A credit load in the same cycle as cfg_load sees the new weight.
    always_comb begin
        pick_w      = cfg_load ? weight_cfg[int'(pick_id)*WEIGHT_W +: WEIGHT_W]
                               : weight_q[pick_id];
        load_credit = mode ? pick_w : WEIGHT_W'(1);
        regrant     = mode && (credit_q > WEIGHT_W'(1)) && bus.req[gnt_id_q];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            credit_q  <= '0;
            gnt_w_q   <= '0;
            gnt_id_q  <= '0;
            gnt_vld_q <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                weight_q[i] <= WEIGHT_W'(1);
            end
        end else begin
            if (cfg_load) begin
                for (int i = 0; i < N_REQ; i++) begin
                    weight_q[i] <= weight_cfg[i*WEIGHT_W +: WEIGHT_W];
                end
            end

            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        state_q   <= GRANT;
                        gnt_w_q   <= pick_onehot;
                        gnt_id_q  <= pick_id;
                        gnt_vld_q <= 1'b1;
                        credit_q  <= load_credit;
                    end
                end

                GRANT: begin
                    if (bus.ack) begin
                        if (regrant) begin
                            credit_q <= credit_q - WEIGHT_W'(1);
                        end else begin
                            ptr_q <= next_id(gnt_id_q);
                            if (pick_any) begin
                                gnt_w_q  <= pick_onehot;
                                gnt_id_q <= pick_id;
                                credit_q <= load_credit;
                            end else begin
                                state_q   <= IDLE;
                                gnt_w_q   <= '0;
                                gnt_id_q  <= '0;
                                gnt_vld_q <= 1'b0;
                            end
                        end
                    end else if (!bus.req[gnt_id_q]) begin
                        // Withdrawal: nothing served, but the turn moves on.
                        ptr_q     <= next_id(gnt_id_q);
                        state_q   <= IDLE;
                        gnt_w_q   <= '0;
                        gnt_id_q  <= '0;
                        gnt_vld_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt_w   = gnt_w_q;
    assign bus.gnt_id  = gnt_id_q;
    assign bus.gnt_vld = gnt_vld_q;
    assign state_dbg   = state_q;

endmodule : wrr_arbiter

// File: tb/tb_wrr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wrr_arbiter
//   Directed bench for wrr_arbiter (N_REQ=32, WEIGHT_W=4). A request-level
//   model predicts the grant every cycle; literal grant sequences pin the
//   model to hand-computed arbitration orders.
// -----------------------------------------------------------------------------
module tb_wrr_arbiter;
    import wrr_pkg::*;

    localparam int N  = 32;
    localparam int WW = 4;
    localparam int IW = 5;

    // ---------------- clock / reset / DUT ----------------
    bit                 clk;
    logic               rst;
    logic               mode;
    logic               cfg_load;
    logic [N*WW-1:0]    weight_cfg;
    wrr_state_e         state_dbg;

    wrr_arbiter_if #(.N_REQ(N), .ID_W(IW)) bus ();

    wrr_arbiter #(
        .N_REQ    (N),
        .WEIGHT_W (WW),
        .ID_W     (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .cfg_load   (cfg_load),
        .weight_cfg (weight_cfg),
        .bus        (bus),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard bookkeeping ----------------
    int          checks;
    int          errors;
    bit          chk_en;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks who holds the grant and how many more back-to-back grants it may
    // take, and picks winners by scanning requesters in rotating order.
    bit m_vld;
    int m_id;
    int m_ptr;
    int m_left;
    int m_pick;
    int m_w  [N];
    int m_nw [N];

    function automatic int scan(input int from);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (from + k) % N;
            if (bus.req[idx] && (!mode || m_w[idx] != 0)) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_vld  = 1'b0;
            m_id   = 0;
            m_ptr  = 0;
            m_left = 0;
            for (int i = 0; i < N; i++) m_w[i] = 1;
        end else begin
            for (int i = 0; i < N; i++)
                m_nw[i] = cfg_load ? int'(weight_cfg[i*WW +: WW]) : m_w[i];
            if (!m_vld) begin
                m_pick = scan(m_ptr);
                if (m_pick >= 0) begin
                    m_vld  = 1'b1;
                    m_id   = m_pick;
                    m_left = mode ? m_nw[m_pick] : 1;
                end
            end else if (bus.ack) begin
                if (mode && m_left > 1 && bus.req[m_id]) begin
                    m_left = m_left - 1;
                end else begin
                    m_ptr  = (m_id + 1) % N;
                    m_pick = scan(m_ptr);
                    if (m_pick >= 0) begin
                        m_id   = m_pick;
                        m_left = mode ? m_nw[m_pick] : 1;
                    end else begin
                        m_vld = 1'b0;
                        m_id  = 0;
                    end
                end
            end else if (!bus.req[m_id]) begin
                m_ptr = (m_id + 1) % N;
                m_vld = 1'b0;
                m_id  = 0;
            end
            for (int i = 0; i < N; i++) m_w[i] = m_nw[i];
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [N-1:0] ew;
        if (chk_en) begin
            ew = '0;
            if (m_vld) ew[m_id] = 1'b1;
            check("model_vld",   32'(bus.gnt_vld), 32'(m_vld));
            check("model_id",    32'(bus.gnt_id),  32'(m_id));
            check("model_gnt_w", bus.gnt_w,        ew);
            check("onehot0",     32'($onehot0(bus.gnt_w)), 32'd1);
            check("state_dbg",   32'(state_dbg == GRANT), 32'(m_vld));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_w1();
        for (int i = 0; i < N; i++) weight_cfg[i*WW +: WW] = WW'(1);
    endtask

    task automatic set_w(input int idx, input int val);
        weight_cfg[idx*WW +: WW] = WW'(val);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        check("rst_vld", 32'(bus.gnt_vld), 32'd0);
        tick();
        rst = 1'b1;
    endtask

    // Each queued id must be the active grant after one more clock.
    task automatic run_seq(input string name);
        logic [31:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tick();
            check({name, "_vld"}, 32'(bus.gnt_vld), 32'd1);
            check({name, "_id"},  32'(bus.gnt_id),  e);
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        checks     = 0;
        errors     = 0;
        chk_en     = 1'b0;
        rst        = 1'b0;
        mode       = 1'b0;
        cfg_load   = 1'b0;
        fill_w1();
        bus.req    = '1;
        bus.ack    = 1'b0;

        // Reset held two cycles with every requester asking.
        tick();
        chk_en = 1'b1;
        check("t1_vld",  32'(bus.gnt_vld), 32'd0);
        check("t1_gntw", bus.gnt_w,        32'd0);
        check("t1_id",   32'(bus.gnt_id),  32'd0);
        tick();
        check("t1_vld2", 32'(bus.gnt_vld), 32'd0);
        rst = 1'b1;
        tick();
        check("t1_first_vld", 32'(bus.gnt_vld), 32'd1);
        check("t1_first_id",  32'(bus.gnt_id),  32'd0);

        // Plain RR, ack every cycle: 1..31 then back to 0, no bubbles.
        bus.ack = 1'b1;
        for (int i = 1; i < N; i++) exp_q.push_back(32'(i));
        exp_q.push_back(32'd0);
        run_seq("t2");

        // WRR weights 3,1,2 on requesters 0..2.
        do_reset();
        mode     = 1'b1;
        set_w(0, 3);
        set_w(1, 1);
        set_w(2, 2);
        cfg_load = 1'b1;
        bus.req  = '0;
        tick();
        cfg_load = 1'b0;
        bus.req  = 32'b111;
        exp_q = '{0, 0, 0, 1, 2, 2, 0};
        run_seq("t3");

        // Weight 0 masks requester 1 in WRR, not in plain RR.
        do_reset();
        fill_w1();
        set_w(1, 0);
        cfg_load = 1'b1;
        bus.req  = '0;
        tick();
        cfg_load = 1'b0;
        bus.req  = 32'b011;
        exp_q = '{0, 0, 0, 0};
        run_seq("t4_wrr");
        mode = 1'b0;
        exp_q = '{1, 0, 1, 0};
        run_seq("t4_rr");

        // Ack while idle is ignored; withdrawal of a held grant.
        do_reset();
        fill_w1();
        bus.req = '0;
        bus.ack = 1'b1;
        tick();
        check("t5_idle_ack", 32'(bus.gnt_vld), 32'd0);
        bus.ack = 1'b0;
        bus.req = 32'h0000_0020;
        tick();
        check("t5_id5_vld", 32'(bus.gnt_vld), 32'd1);
        check("t5_id5",     32'(bus.gnt_id),  32'd5);
        bus.req = 32'h0000_0040;
        tick();
        check("t5_wd_vld",  32'(bus.gnt_vld), 32'd0);
        check("t5_wd_gntw", bus.gnt_w,        32'd0);
        bus.req = 32'h0000_0060;
        tick();
        check("t5_id6_vld", 32'(bus.gnt_vld), 32'd1);
        check("t5_id6",     32'(bus.gnt_id),  32'd6);
        check("t5_id6_w",   bus.gnt_w,        32'h0000_0040);

        // Weight change mid-burst leaves the running credit alone.
        do_reset();
        mode = 1'b1;
        fill_w1();
        set_w(0, 3);
        cfg_load = 1'b1;
        bus.req  = '0;
        tick();
        cfg_load = 1'b0;
        bus.req  = 32'b11;
        bus.ack  = 1'b1;
        tick();
        check("t6_first", 32'(bus.gnt_id), 32'd0);
        set_w(0, 1);
        cfg_load = 1'b1;
        tick();
        check("t6_second", 32'(bus.gnt_id), 32'd0);
        cfg_load = 1'b0;
        exp_q = '{0, 1, 0, 1};
        run_seq("t6");
        // Load and credit load in the same cycle: the new weight 2 applies.
        set_w(0, 2);
        cfg_load = 1'b1;
        tick();
        check("t6_newcred", 32'(bus.gnt_id), 32'd0);
        cfg_load = 1'b0;
        exp_q = '{0, 1};
        run_seq("t6b");

        // Reset in the middle of a grant drops it on the next cycle.
        rst = 1'b0;
        tick();
        check("t7_rst_vld",  32'(bus.gnt_vld), 32'd0);
        check("t7_rst_gntw", bus.gnt_w,        32'd0);
        rst = 1'b1;
        bus.ack = 1'b0;
        bus.req = '0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_wrr_arbiter
